dbc_arbiter: RTL and testbench
==============================

Name: dbc_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the data bus controller (DataBusControl).
- Master 0 is the CPU load/store unit; master 1 is the debug/loader port (program load, memory inspection).
- Serialises one access at a time and drives the controller's wd/rd/size/addr/data strobes.
- Returns read data and a one-cycle ack to the winning master; round-robin fairness under contention.

Parameters:
- ADDR_W, 32, address width of both masters and the controller.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 15, maximum ACCESS cycles with dbc_ready low before the access is aborted with error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- m_req  in  2  per-master request, bit i = master i
- m_we  in  2  per-master write enable (1 write, 0 read)
- m0_addr, m1_addr  in  ADDR_W each  byte address
- m0_size, m1_size  in  2 each  00 byte, 01 half, 10 word; 11 reserved
- m0_wdata, m1_wdata  in  DATA_W each  write data
- m_ack  out  2  one-cycle completion pulse per master
- m_err  out  2  valid with m_ack; 1 = aborted or rejected
- m_rdata  out  DATA_W  shared read data, valid with either ack
- dbc_wd, dbc_rd  out  1 each  controller write/read strobes
- dbc_size  out  2  driven to both size_in and size_out
- dbc_addr  out  ADDR_W  driven to both addr_in and addr_out
- dbc_wdata  out  DATA_W  controller data_in
- dbc_rdata  in  DATA_W  controller data_out
- dbc_ready  in  1  controller ready

Behaviour:
- Reset values (rst=0 at clk edge): state IDLE; m_ack=0, m_err=0, m_rdata=0; dbc_wd=0, dbc_rd=0, dbc_addr=0, dbc_size=0, dbc_wdata=0; last_grant=1, so master 0 wins the first tie; timeout counter=0.
- A reset mid-transaction abandons it: no ack is issued, all strobes drop on the same edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any m_req is set, pick the winner: the sole requester, or on a tie the master not equal to last_grant.
  - Latch the winner's we/addr/size/wdata into dbc_* registers; set last_grant to the winner; go to ACCESS.
  - Size 11 is rejected: go to RESP with err=1 and no strobes.
- ACCESS:
  - dbc_rd = !we, dbc_wd = we, both registered; address, size and data held stable.
  - If dbc_ready=1: capture dbc_rdata into m_rdata (reads only), drop the strobes, go to RESP with err=0. The write commits in the controller on this edge.
  - If dbc_ready=0: increment the timeout counter. When it reaches TIMEOUT_CYCLES, drop the strobes and go to RESP with err=1; m_rdata is then 0.
- RESP:
  - m_ack[winner]=1 for exactly one cycle; m_err[winner] as determined above; then IDLE.
  - The ack of the other master is always 0.
- Latency, uncontended, dbc_ready=1: req sampled at edge n, strobes active in cycle n+1, ack in cycle n+2. Throughput is one access per 3 cycles.
- Requester protocol:
  - Hold req and fields stable until the ack cycle; deassert or issue a new request in the cycle after ack.
  - A req still high in IDLE after ack is treated as a new request.
  - Dropping req before ack does not cancel the access; ack is still pulsed.
- m_rdata holds its value until the next read capture.
- Strobes are never asserted outside ACCESS, and wd/rd are never high together.

Optional Feature:
- Macro DBC_ARB_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a granted request with size 01 and addr[0]=1, or size 10 and addr[1:0]≠00, skips ACCESS and goes to RESP with err=1.
  - The controller never sees misaligned accesses.
- Undefined:
  - Misaligned requests are forwarded unchanged; the controller's own misalignment register reports them.

Decomposition:
- Shared package/header (next to MemoryMap.vh): size encodings SIZE_BYTE/HALF/WORD, FSM state encodings, TIMEOUT_CYCLES default.
- One natural sub-module: dbc_rr_pick, the 2-way round-robin priority selector (req[1:0], last_grant → grant_onehot). It is combinational and reused by a later instruction/data bus arbiter.

Test Plan:
- Single read: M0 reads addr 0x10, size 10, memory word 0xDEADBEEF, ready=1 → dbc_rd high for exactly one cycle; m_ack[0] two cycles after req sampled; m_rdata=0xDEADBEEF, m_err=0.
- Contention: both masters request in the same cycle after reset → M0 served first, then M1. Both hold requests → grants alternate 0,1,0,1; neither master waits more than one transaction.
- Write then read: M1 writes 0x000000AB size 00 to 0x20, then M0 reads 0x20 size 00 → m_rdata=0x000000AB.
- Timeout: dbc_ready held 0 for 20 cycles → ack with m_err=1 after exactly 15 ACCESS cycles; strobes drop; m_rdata=0.
- Reset mid-ACCESS: rst=0 while dbc_wd=1 → next cycle all outputs at reset values, no ack, last_grant=1.
- Alignment (macro on): M0 word read at 0x22 → m_ack[0]=1, m_err[0]=1, dbc_rd never asserted. Macro off: the same request asserts dbc_rd.

Source files
------------

// File: rtl/dbc_arbiter_pkg.sv
// Shared encodings for the data-bus arbiter: access sizes, FSM states, default abort timeout.
package dbc_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam int TIMEOUT_CYCLES_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dbc_rr_pick.sv
// Two-way round-robin selector: a sole requester wins, a tie goes to the master not granted last.
module dbc_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = i_last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dbc_arbiter.sv
// Serialises two masters onto the data bus controller; ack two cycles after grant when ready, abort after TIMEOUT_CYCLES stalled cycles.
// DBC_ARB_ALIGN_CHECK_EN rejects misaligned half/word accesses before they reach the controller.
module dbc_arbiter
  import dbc_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m0_size,
  input  logic [1:0]        m1_size,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [1:0]        m_ack,
  output logic [1:0]        m_err,
  output logic [DATA_W-1:0] m_rdata,
  output logic              dbc_wd,
  output logic              dbc_rd,
  output logic [1:0]        dbc_size,
  output logic [ADDR_W-1:0] dbc_addr,
  output logic [DATA_W-1:0] dbc_wdata,
  input  logic [DATA_W-1:0] dbc_rdata,
  input  logic              dbc_ready
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t            r_state, w_state_nxt;
  logic              r_last_grant, w_last_grant_nxt;
  logic              r_cur, w_cur_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_ack, w_ack_nxt;
  logic [1:0]        r_err, w_err_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_wd, w_wd_nxt;
  logic              r_rd, w_rd_nxt;
  logic [1:0]        r_size, w_size_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;

  logic [1:0]        w_grant;
  logic              w_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [1:0]        w_sel_size;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_reject;

  dbc_rr_pick u_rr_pick (
    .i_req        (m_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_win       = w_grant[1];
  assign w_sel_we    = m_we[w_win];
  assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
  assign w_sel_size  = w_win ? m1_size  : m0_size;
  assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;

`ifdef DBC_ARB_ALIGN_CHECK_EN
  assign w_reject = (w_sel_size == SIZE_RSVD) || is_misaligned(w_sel_size, w_sel_addr[1:0]);
`else
  assign w_reject = (w_sel_size == SIZE_RSVD);
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_cur_nxt        = r_cur;
    w_cnt_nxt        = r_cnt;
    w_ack_nxt        = 2'b00;
    w_err_nxt        = 2'b00;
    w_rdata_nxt      = r_rdata;
    w_wd_nxt         = r_wd;
    w_rd_nxt         = r_rd;
    w_size_nxt       = r_size;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;

    case (r_state)
      ST_IDLE: begin
        if (|m_req) begin
          w_last_grant_nxt = w_win;
          w_cur_nxt        = w_win;
          if (w_reject) begin
            // Rejected requests never touch the controller; ack straight away with error.
            w_ack_nxt[w_win] = 1'b1;
            w_err_nxt[w_win] = 1'b1;
            w_state_nxt      = ST_RESP;
          end else begin
            w_wd_nxt    = w_sel_we;
            w_rd_nxt    = !w_sel_we;
            w_addr_nxt  = w_sel_addr;
            w_size_nxt  = w_sel_size;
            w_wdata_nxt = w_sel_wdata;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        if (dbc_ready) begin
          w_wd_nxt         = 1'b0;
          w_rd_nxt         = 1'b0;
          if (r_rd) begin
            w_rdata_nxt = dbc_rdata;
          end
          w_ack_nxt[r_cur] = 1'b1;
          w_state_nxt      = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_cnt_nxt == CNT_MAX) begin
            w_wd_nxt         = 1'b0;
            w_rd_nxt         = 1'b0;
            w_rdata_nxt      = '0;
            w_ack_nxt[r_cur] = 1'b1;
            w_err_nxt[r_cur] = 1'b1;
            w_state_nxt      = ST_RESP;
          end
        end
      end

      ST_RESP: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_cur        <= 1'b0;
      r_cnt        <= '0;
      r_ack        <= 2'b00;
      r_err        <= 2'b00;
      r_rdata      <= '0;
      r_wd         <= 1'b0;
      r_rd         <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cur        <= w_cur_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ack        <= w_ack_nxt;
      r_err        <= w_err_nxt;
      r_rdata      <= w_rdata_nxt;
      r_wd         <= w_wd_nxt;
      r_rd         <= w_rd_nxt;
      r_size       <= w_size_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
    end
  end

  assign m_ack     = r_ack;
  assign m_err     = r_err;
  assign m_rdata   = r_rdata;
  assign dbc_wd    = r_wd;
  assign dbc_rd    = r_rd;
  assign dbc_size  = r_size;
  assign dbc_addr  = r_addr;
  assign dbc_wdata = r_wdata;

endmodule

// File: tb/tb_dbc_arbiter.sv
// Bench for dbc_arbiter: emulated controller memory, transaction-level reference model, scoreboard on acks and bus accesses.
`timescale 1ns/1ps
module tb_dbc_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  m_req = 2'b00;
  logic [1:0]  m_we = 2'b00;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [1:0]  m0_size = '0, m1_size = '0;
  logic [1:0]  m_ack, m_err;
  logic [31:0] m_rdata;
  logic        dbc_wd, dbc_rd, dbc_ready;
  logic [1:0]  dbc_size;
  logic [31:0] dbc_addr, dbc_wdata, dbc_rdata;

  dbc_arbiter dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_size(m0_size), .m1_size(m1_size),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .dbc_wd(dbc_wd), .dbc_rd(dbc_rd), .dbc_size(dbc_size), .dbc_addr(dbc_addr),
    .dbc_wdata(dbc_wdata), .dbc_rdata(dbc_rdata), .dbc_ready(dbc_ready)
  );

  initial forever #5 clk = ~clk;

  // Controller emulation: ready after ready_delay strobe cycles, word store keyed by byte address.
  logic [31:0] emu_mem [64];
  int          wait_cnt = 0;
  int          ready_delay = 0;

  always @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= 0;
      for (int i = 0; i < 64; i++) emu_mem[i] <= '0;
    end else begin
      if (dbc_wd || dbc_rd) wait_cnt <= wait_cnt + 1;
      else                  wait_cnt <= 0;
      if (dbc_wd && dbc_ready) emu_mem[dbc_addr[5:0]] <= dbc_wdata;
    end
  end

  assign dbc_ready = (wait_cnt >= ready_delay);
  assign dbc_rdata = emu_mem[dbc_addr[5:0]];

  typedef struct { int m; bit err; logic [31:0] rdata; } exp_t;
  typedef struct { bit we; logic [31:0] addr; logic [1:0] size; logic [31:0] wdata; int len; } acc_t;

  exp_t        exp_q[$];
  acc_t        acc_q[$];
  logic [31:0] mdl_mem [64];
  logic [31:0] mdl_rdata;
  bit          mdl_last;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
    mdl_rdata = '0;
    mdl_last  = 1'b1;
  endtask

  // One access as the spec describes it: outcome, data returned, and what the controller should see.
  task automatic model_serve(input int m, input bit we, input logic [31:0] addr,
                             input logic [1:0] size, input logic [31:0] wd, input int delay);
    bit rej;
    exp_t e;
    acc_t a;
    rej = (size == 2'b11);
`ifdef DBC_ARB_ALIGN_CHECK_EN
    rej = rej || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`endif
    e.m = m;
    if (rej) begin
      e.err = 1'b1;
    end else begin
      a.we = we; a.addr = addr; a.size = size; a.wdata = wd;
      a.len = (delay >= TO) ? TO : delay + 1;
      acc_q.push_back(a);
      if (delay >= TO) begin
        e.err = 1'b1;
        mdl_rdata = '0;
      end else begin
        e.err = 1'b0;
        if (we) mdl_mem[addr[5:0]] = wd;
        else    mdl_rdata = mdl_mem[addr[5:0]];
      end
    end
    e.rdata = mdl_rdata;
    exp_q.push_back(e);
    mdl_last = (m == 1);
  endtask

  task automatic batch(input bit r0, input bit r1, input bit we0, input bit we1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] s0, input logic [1:0] s1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input int delay, output int lat);
    int n;
    ready_delay = delay;
    if (r0 && r1) begin
      if (mdl_last) begin
        model_serve(0, we0, a0, s0, d0, delay);
        model_serve(1, we1, a1, s1, d1, delay);
      end else begin
        model_serve(1, we1, a1, s1, d1, delay);
        model_serve(0, we0, a0, s0, d0, delay);
      end
    end else if (r0) begin
      model_serve(0, we0, a0, s0, d0, delay);
    end else if (r1) begin
      model_serve(1, we1, a1, s1, d1, delay);
    end
    @(negedge clk);
    m_we = {we1, we0};
    m0_addr = a0; m1_addr = a1; m0_size = s0; m1_size = s1; m0_wdata = d0; m1_wdata = d1;
    m_req = {r1, r0};
    lat = -1;
    n = 0;
    while (m_req != 2'b00 && n < 400) begin
      @(negedge clk);
      n++;
      if (m_ack != 2'b00 && lat < 0) lat = n;
      m_req = m_req & ~m_ack;
    end
    chk("batch_done", {62'd0, m_req}, 64'd0);
    m_req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat, n, pick, dly;
    bit ractive;
    int rlen, rexp;
    model_reset();
    ractive = 1'b0; rlen = 0; rexp = -1;

    fork
      forever begin : monitor
        exp_t e;
        acc_t a;
        @(negedge clk);
        if (!rst) begin
          ractive = 1'b0;
        end else begin
          chk("err_without_ack", 64'((m_err & ~m_ack) != 2'b00), 64'd0);
          chk("wd_rd_exclusive", 64'(dbc_wd && dbc_rd), 64'd0);
          if (m_ack != 2'b00) begin
            chk("ack_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("ack_master", {62'd0, m_ack}, 64'(2'b01 << e.m));
              chk("ack_err", {62'd0, m_err}, e.err ? 64'(2'b01 << e.m) : 64'd0);
              chk("rdata", {32'd0, m_rdata}, {32'd0, e.rdata});
            end
          end
          if ((dbc_wd || dbc_rd) && !ractive) begin
            chk("access_expected", 64'(acc_q.size() != 0), 64'd1);
            rexp = -1;
            if (acc_q.size() != 0) begin
              a = acc_q.pop_front();
              chk("bus_we", {63'd0, dbc_wd}, {63'd0, a.we});
              chk("bus_addr", {32'd0, dbc_addr}, {32'd0, a.addr});
              chk("bus_size", {62'd0, dbc_size}, {62'd0, a.size});
              if (a.we) chk("bus_wdata", {32'd0, dbc_wdata}, {32'd0, a.wdata});
              rexp = a.len;
            end
            ractive = 1'b1;
            rlen = 1;
          end else if (dbc_wd || dbc_rd) begin
            rlen++;
          end else if (ractive) begin
            if (rexp >= 0) chk("strobe_len", 64'(rlen), 64'(rexp));
            ractive = 1'b0;
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {62'd0, m_ack}, 64'd0);
    chk("rst_err", {62'd0, m_err}, 64'd0);
    chk("rst_rdata", {32'd0, m_rdata}, 64'd0);
    chk("rst_strobes", {62'd0, dbc_wd, dbc_rd}, 64'd0);
    chk("rst_addr", {32'd0, dbc_addr}, 64'd0);
    chk("rst_size", {62'd0, dbc_size}, 64'd0);
    chk("rst_wdata", {32'd0, dbc_wdata}, 64'd0);
    rst = 1'b1;

    // Tie right after reset: M0 reads 0x10 first, then M1 writes DEADBEEF there.
    batch(1, 1, 0, 1, 32'h10, 32'h10, 2'b10, 2'b10, 0, 32'hDEADBEEF, 0, lat);
    batch(1, 0, 0, 0, 32'h10, 0, 2'b10, 0, 0, 0, 0, lat);
    chk("read_latency", 64'(lat), 64'd2);
    batch(0, 1, 0, 1, 0, 32'h20, 0, 2'b00, 0, 32'h000000AB, 0, lat);
    batch(1, 0, 0, 0, 32'h20, 0, 2'b00, 0, 0, 0, 0, lat);
    for (int i = 0; i < 4; i++)
      batch(1, 1, 0, 0, 32'h10, 32'h20, 2'b10, 2'b00, 0, 0, 1, lat);
    batch(1, 0, 0, 0, 32'h20, 0, 2'b10, 0, 0, 0, 20, lat);
    chk("timeout_latency", 64'(lat), 64'd16);
    batch(0, 1, 0, 1, 0, 32'h24, 0, 2'b10, 0, 32'h55AA55AA, TO, lat);
    batch(1, 0, 0, 0, 32'h24, 0, 2'b10, 0, 0, 0, TO - 1, lat);
    batch(1, 0, 0, 0, 32'h22, 0, 2'b10, 0, 0, 0, 0, lat);
    batch(0, 1, 0, 0, 0, 32'h30, 0, 2'b11, 0, 0, 0, lat);

    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(1, 3);
      dly  = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(0, 3);
      batch(pick[0], pick[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)), 32'($urandom_range(0, 63)),
            ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
            ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
            32'($urandom), 32'($urandom), dly, lat);
    end

    // Reset while a write is stalled in ACCESS: everything drops, no ack follows.
    ready_delay = 20;
    model_serve(0, 1, 32'h30, 2'b10, 32'h12345678, 20);
    @(negedge clk);
    m_we = 2'b01; m0_addr = 32'h30; m0_size = 2'b10; m0_wdata = 32'h12345678; m_req = 2'b01;
    n = 0;
    while (!dbc_wd && n < 10) begin @(negedge clk); n++; end
    chk("wd_before_reset", {63'd0, dbc_wd}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    m_req = 2'b00;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    chk("mid_rst_ack", {62'd0, m_ack}, 64'd0);
    chk("mid_rst_strobes", {62'd0, dbc_wd, dbc_rd}, 64'd0);
    chk("mid_rst_addr", {32'd0, dbc_addr}, 64'd0);
    chk("mid_rst_wdata", {32'd0, dbc_wdata}, 64'd0);
    chk("mid_rst_rdata", {32'd0, m_rdata}, 64'd0);
    @(negedge clk);
    chk("mid_rst_no_ack", {62'd0, m_ack}, 64'd0);
    rst = 1'b1;
    model_reset();
    batch(1, 1, 0, 1, 32'h08, 32'h08, 2'b10, 2'b10, 0, 32'hCAFEF00D, 0, lat);
    batch(1, 0, 0, 0, 32'h08, 0, 2'b10, 0, 0, 0, 2, lat);

    repeat (5) @(negedge clk);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
    chk("acc_drained", 64'(acc_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
